maze_generator: RTL and testbench

//  Builds a random perfect maze (spanning tree, one route between any two cells) for the maze

---
 rtl/maze_pkg.sv | 32 +++
 rtl/maze_lfsr16.sv | 37 +++
 rtl/maze_generator.sv | 187 ++++++++++++++++++
 tb/tb_maze_generator.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared types and constants for the maze generator and solver.
//   dir_e        : neighbour direction (LEFT/RIGHT/DOWN/UP, NONE = no move)
//   gen_state_e  : generator sequencing states
//   LFSR_POLY    : Galois feedback taps, x^16+x^14+x^13+x^11+1
//   LFSR_DEFAULT : reset value, also substituted for an all-zero seed
package maze_pkg;

  typedef enum logic [2:0] {
    LEFT  = 3'd0,
    RIGHT = 3'd1,
    DOWN  = 3'd2,
    UP    = 3'd3,
    NONE  = 3'd4
  } dir_e;

  typedef enum logic [2:0] {
    GEN_IDLE,
    GEN_INIT,
    GEN_CARVE,
    GEN_FINISH,
    GEN_DONE
  } gen_state_e;

  localparam logic [15:0] LFSR_POLY    = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

  // One right-shifting Galois step.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/maze_lfsr16.sv
// 16-bit Galois LFSR used as the maze generator's random source.
//   clk, rst_n : clock, asynchronous active-low reset (state -> LFSR_DEFAULT)
//   load       : take seed (zero seed replaced by LFSR_DEFAULT); wins over advance
//   seed       : seed value
//   advance    : step the LFSR once
//   state      : current LFSR state
module maze_lfsr16 import maze_pkg::*; (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        advance,
  output logic [15:0] state
);

  logic [15:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (seed == '0) ? LFSR_DEFAULT : seed;
    end else if (advance) begin
      state_d = lfsr_step(state_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LFSR_DEFAULT;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/maze_generator.sv
// Random perfect-maze generator (randomized depth-first backtracker).
// maze[row][col], 1 = wall, 0 = open; entrance maze[0][1], exit maze[SIZE-1][SIZE-2].
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begins a generation when idle or done
//   seed       : LFSR seed, sampled when start is accepted
//   busy       : generation in progress
//   done       : maze complete and stable until the next accepted start
//   maze       : SIZE x SIZE maze array
module maze_generator import maze_pkg::*; #(
  parameter int SIZE = 9,
  parameter int N    = 4,
  parameter int SW   = $clog2(((SIZE - 1) / 2) * ((SIZE - 1) / 2)) + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [15:0]                seed,
  output logic                       busy,
  output logic                       done,
  output logic [SIZE-1:0][SIZE-1:0]  maze
);

  localparam int          C     = (SIZE - 1) / 2;
  localparam int unsigned DEPTH = C * C;
  localparam int          CW    = (C > 1) ? $clog2(C) : 1;
  localparam int          AW    = $clog2(C * C);
  localparam logic [AW-1:0] C_A   = AW'(C);
  localparam logic [CW-1:0] C_MAX = CW'(C - 1);

  gen_state_e               state_q, state_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [SIZE-1:0][SIZE-1:0] maze_q, maze_d;
  logic [DEPTH-1:0]         visited_q, visited_d;
  logic [2*CW-1:0]          stack_q [DEPTH];
  logic [2*CW-1:0]          stack_d [DEPTH];
  logic [SW-1:0]            sp_q, sp_d;

  logic [15:0]   lfsr_state;
  logic          lfsr_load, lfsr_adv;
  logic          lfsr_unused;

  logic [AW-1:0]   top_ptr, cur_idx, n_idx;
  logic [2*CW-1:0] top;
  logic [CW-1:0]   cx, cy, nx, ny;
  logic [3:0]      mask;
  logic [1:0]      pick;
  logic            found;
  dir_e            dir_sel;
  logic [N-1:0]    row, col, wr, wc, nr, nc;

  maze_lfsr16 u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (lfsr_load),
    .seed    (seed),
    .advance (lfsr_adv),
    .state   (lfsr_state)
  );

  // Only the two low LFSR bits steer direction choice.
  assign lfsr_unused = ^lfsr_state[15:2];

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = done_q;
    maze_d    = maze_q;
    visited_d = visited_q;
    stack_d   = stack_q;
    sp_d      = sp_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;

    // Current cell = top of stack; cell index is cy*C+cx into the visited bitmap.
    top_ptr = AW'(sp_q - 1'b1);
    top     = stack_q[top_ptr];
    cx      = top[CW-1:0];
    cy      = top[2*CW-1:CW];
    cur_idx = AW'(cy) * C_A + AW'(cx);

    // Edge cells never look past the grid boundary.
    mask[0] = (cx != '0)    ? !visited_q[cur_idx - 1'b1] : 1'b0;
    mask[1] = (cx != C_MAX) ? !visited_q[cur_idx + 1'b1] : 1'b0;
    mask[2] = (cy != C_MAX) ? !visited_q[cur_idx + C_A]  : 1'b0;
    mask[3] = (cy != '0)    ? !visited_q[cur_idx - C_A]  : 1'b0;

    // Rotating priority starting at lfsr[1:0].
    found   = 1'b0;
    pick    = '0;
    dir_sel = LEFT;
    for (int unsigned k = 0; k < 4; k++) begin
      pick = lfsr_state[1:0] + 2'(k);
      if (!found && mask[pick]) begin
        found   = 1'b1;
        dir_sel = dir_e'({1'b0, pick});
      end
    end

    row   = N'({cy, 1'b1});
    col   = N'({cx, 1'b1});
    wr    = row;
    wc    = col;
    nr    = row;
    nc    = col;
    nx    = cx;
    ny    = cy;
    n_idx = cur_idx;
    case (dir_sel)
      LEFT:    begin wc = col - 1'b1; nc = col - 2'd2; nx = cx - 1'b1; n_idx = cur_idx - 1'b1; end
      RIGHT:   begin wc = col + 1'b1; nc = col + 2'd2; nx = cx + 1'b1; n_idx = cur_idx + 1'b1; end
      DOWN:    begin wr = row + 1'b1; nr = row + 2'd2; ny = cy + 1'b1; n_idx = cur_idx + C_A;  end
      UP:      begin wr = row - 1'b1; nr = row - 2'd2; ny = cy - 1'b1; n_idx = cur_idx - C_A;  end
      default: ;
    endcase

    case (state_q)
      GEN_IDLE, GEN_DONE: begin
        if (start) begin
          lfsr_load = 1'b1;
          done_d    = 1'b0;
          busy_d    = 1'b1;
          state_d   = GEN_INIT;
        end
      end
      GEN_INIT: begin
        maze_d       = '1;
        maze_d[1][1] = 1'b0;
        visited_d    = '0;
        visited_d[0] = 1'b1;
        stack_d[0]   = '0;
        sp_d         = SW'(1);
        state_d      = GEN_CARVE;
      end
      GEN_CARVE: begin
        lfsr_adv = 1'b1;
        if (found) begin
          maze_d[wr][wc]           = 1'b0;
          maze_d[nr][nc]           = 1'b0;
          visited_d[n_idx]         = 1'b1;
          stack_d[AW'(sp_q)]       = {ny, nx};
          sp_d                     = sp_q + 1'b1;
        end else begin
          sp_d = sp_q - 1'b1;
          if (sp_q == SW'(1)) begin
            state_d = GEN_FINISH;
          end
        end
      end
      GEN_FINISH: begin
        maze_d[0][1]           = 1'b0;
        maze_d[SIZE-1][SIZE-2] = 1'b0;
        busy_d                 = 1'b0;
        done_d                 = 1'b1;
        state_d                = GEN_DONE;
      end
      default: state_d = GEN_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= GEN_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      maze_q    <= '1;
      visited_q <= '0;
      sp_q      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      maze_q    <= maze_d;
      visited_q <= visited_d;
      sp_q      <= sp_d;
      stack_q   <= stack_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign maze = maze_q;

endmodule

// File: tb/tb_maze_generator.sv
// Self-checking bench for maze_generator (SIZE=9) against a queue-based
// depth-first backtracker reference model.
module tb_maze_generator;

  localparam int S   = 9;
  localparam int C   = (S - 1) / 2;
  localparam int LAT = 2 * C * C + 2;  // edges from raising start (accept edge = 1) to done

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic [15:0]          seed;
  logic                 busy;
  logic                 done;
  logic [S-1:0][S-1:0]  maze;

  int checks = 0;
  int errors = 0;

  logic [S-1:0][S-1:0]  exp_maze;

  maze_generator #(.SIZE(S), .N(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .seed  (seed),
    .busy  (busy),
    .done  (done),
    .maze  (maze)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [15:0] model_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  task automatic model_gen(input logic [15:0] s);
    logic [15:0] lf;
    bit          vis [C][C];
    int          stk[$];
    int          dx[4] = '{-1, 1, 0, 0};
    int          dy[4] = '{0, 0, 1, -1};
    int          x, y, nx, ny, r, d, pk;
    lf = (s == 16'h0000) ? 16'hACE1 : s;
    exp_maze = '1;
    exp_maze[1][1] = 1'b0;
    foreach (vis[i, j]) vis[i][j] = 1'b0;
    vis[0][0] = 1'b1;
    stk.push_back(0);
    while (stk.size() > 0) begin
      x  = stk[$] % C;
      y  = stk[$] / C;
      r  = int'(lf[1:0]);
      lf = model_step(lf);
      pk = -1;
      for (int k = 0; k < 4; k++) begin
        d  = (r + k) % 4;
        nx = x + dx[d];
        ny = y + dy[d];
        if (pk < 0 && nx >= 0 && nx < C && ny >= 0 && ny < C) begin
          if (!vis[ny][nx]) pk = d;
        end
      end
      if (pk >= 0) begin
        nx = x + dx[pk];
        ny = y + dy[pk];
        exp_maze[2*y+1+dy[pk]][2*x+1+dx[pk]] = 1'b0;
        exp_maze[2*ny+1][2*nx+1] = 1'b0;
        vis[ny][nx] = 1'b1;
        stk.push_back(ny * C + nx);
      end else begin
        void'(stk.pop_back());
      end
    end
    exp_maze[0][1]     = 1'b0;
    exp_maze[S-1][S-2] = 1'b0;
  endtask

  // Drive one start pulse and wait (bounded) for done; edges counts the accept edge as 1.
  task automatic run_gen(input logic [15:0] s, output int edges, output logic busy_seen,
                         output logic done_seen);
    @(negedge clk);
    seed  = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    edges     = 1;
    busy_seen = busy;
    done_seen = done;
    while (done !== 1'b1 && edges < LAT + 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    seed  = 16'h0000;
    #12;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++;
    if (maze !== {S*S{1'b1}}) begin errors++; $display("FAIL reset_maze: got %h expected all ones", maze); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    int e;
    logic b, d;
    run_gen(16'h0001, e, b, d);
    model_gen(16'h0001);
    checks++;
    if (b !== 1'b1 || d !== 1'b0) begin errors++; $display("FAIL accept_flags: busy=%b done=%b expected busy=1 done=0", b, d); end
    checks++;
    if (e != LAT) begin errors++; $display("FAIL latency: got %0d edges expected %0d", e, LAT); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_done: got %b expected 0", busy); end
    checks++;
    if (maze !== exp_maze) begin errors++; $display("FAIL maze_seed1: got %h expected %h", maze, exp_maze); end
  endtask

  task automatic test_structure();
    int bad_border, bad_cell, bad_post, opened, reach;
    bit seen [S][S];
    int q[$];
    int p, r, c, nr, nc;
    int dr[4] = '{0, 0, 1, -1};
    int dc[4] = '{-1, 1, 0, 0};
    bad_border = 0; bad_cell = 0; bad_post = 0; opened = 0; reach = 0;
    for (int i = 0; i < S; i++) begin
      for (int j = 0; j < S; j++) begin
        seen[i][j] = 1'b0;
        if (i == 0 || j == 0 || i == S-1 || j == S-1) begin
          if ((i == 0 && j == 1) || (i == S-1 && j == S-2)) begin
            if (maze[i][j] !== 1'b0) bad_border++;
          end else if (maze[i][j] !== 1'b1) bad_border++;
        end else if ((i % 2) == 1 && (j % 2) == 1) begin
          if (maze[i][j] !== 1'b0) bad_cell++;
        end else if ((i % 2) == 0 && (j % 2) == 0) begin
          if (maze[i][j] !== 1'b1) bad_post++;
        end else if (maze[i][j] === 1'b0) opened++;
      end
    end
    seen[0][1] = 1'b1;
    q.push_back(1);
    while (q.size() > 0) begin
      p = q.pop_front();
      r = p / S;
      c = p % S;
      if ((r % 2) == 1 && (c % 2) == 1) reach++;
      for (int k = 0; k < 4; k++) begin
        nr = r + dr[k];
        nc = c + dc[k];
        if (nr >= 0 && nr < S && nc >= 0 && nc < S) begin
          if (!seen[nr][nc] && maze[nr][nc] === 1'b0) begin
            seen[nr][nc] = 1'b1;
            q.push_back(nr * S + nc);
          end
        end
      end
    end
    checks++;
    if (bad_border != 0) begin errors++; $display("FAIL border: got %0d bad squares expected 0", bad_border); end
    checks++;
    if (bad_cell != 0) begin errors++; $display("FAIL cells_open: got %0d closed cells expected 0", bad_cell); end
    checks++;
    if (bad_post != 0) begin errors++; $display("FAIL posts: got %0d open posts expected 0", bad_post); end
    checks++;
    if (opened != C*C-1) begin errors++; $display("FAIL opened_walls: got %0d expected %0d", opened, C*C-1); end
    checks++;
    if (reach != C*C) begin errors++; $display("FAIL flood_cells: got %0d expected %0d", reach, C*C); end
    checks++;
    if (seen[S-1][S-2] !== 1'b1) begin errors++; $display("FAIL exit_reach: got %b expected 1", seen[S-1][S-2]); end
  endtask

  task automatic test_seeds();
    logic [15:0] seeds[$];
    int e;
    logic b, d;
    seeds = '{16'h0000, 16'hACE1, 16'h0002, 16'hFFFF};
    for (int i = 0; i < 4; i++) seeds.push_back(16'($urandom));
    foreach (seeds[i]) begin
      run_gen(seeds[i], e, b, d);
      model_gen(seeds[i]);
      checks++;
      if (e != LAT) begin errors++; $display("FAIL seed_latency %h: got %0d edges expected %0d", seeds[i], e, LAT); end
      checks++;
      if (maze !== exp_maze) begin errors++; $display("FAIL seed_maze %h: got %h expected %h", seeds[i], maze, exp_maze); end
    end
  endtask

  task automatic test_busy_start();
    int e;
    @(negedge clk);
    seed  = 16'h1234;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e = 1;
    while (done !== 1'b1 && e < LAT + 20) begin
      if (e == 5 || e == 20) begin
        start = 1'b1;
        seed  = 16'h5A5A;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      e++;
    end
    model_gen(16'h1234);
    checks++;
    if (e != LAT) begin errors++; $display("FAIL busy_start_latency: got %0d edges expected %0d", e, LAT); end
    checks++;
    if (maze !== exp_maze) begin errors++; $display("FAIL busy_start_maze: got %h expected %h", maze, exp_maze); end
  endtask

  task automatic test_reset_mid();
    int e;
    logic b, d;
    @(negedge clk);
    seed  = 16'h00C3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midreset_flags: busy=%b done=%b expected 0 0", busy, done); end
    checks++;
    if (maze !== {S*S{1'b1}}) begin errors++; $display("FAIL midreset_maze: got %h expected all ones", maze); end
    @(negedge clk);
    rst_n = 1'b1;
    run_gen(16'h00C3, e, b, d);
    model_gen(16'h00C3);
    checks++;
    if (e != LAT) begin errors++; $display("FAIL rerun_latency: got %0d edges expected %0d", e, LAT); end
    checks++;
    if (maze !== exp_maze) begin errors++; $display("FAIL rerun_maze: got %h expected %h", maze, exp_maze); end
  endtask

  task automatic test_back_to_back();
    int e, unstable;
    logic b, d;
    unstable = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done !== 1'b1 || maze !== exp_maze) unstable++;
    end
    checks++;
    if (unstable != 0) begin errors++; $display("FAIL done_hold: got %0d unstable cycles expected 0", unstable); end
    run_gen(16'hBEEF, e, b, d);
    model_gen(16'hBEEF);
    checks++;
    if (b !== 1'b1 || d !== 1'b0) begin errors++; $display("FAIL restart_flags: busy=%b done=%b expected busy=1 done=0", b, d); end
    checks++;
    if (e != LAT) begin errors++; $display("FAIL restart_latency: got %0d edges expected %0d", e, LAT); end
    checks++;
    if (maze !== exp_maze) begin errors++; $display("FAIL restart_maze: got %h expected %h", maze, exp_maze); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_structure();
    test_seeds();
    test_busy_start();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
